// File: rtl/mux4_rr_sched_if.sv
// Bus bundle between the four producers, the round-robin scheduler and the
// single downstream consumer.
//
// Handshake: y_valid/y is offered by the scheduler; a beat moves on every
// rising clk edge where y_valid && y_ready are both high. While y_valid is
// high and y_ready is low, the beat is held stable (sel and gnt do not move)
// as long as the granted producer keeps its data stable. y_ready may be
// driven without looking at y_valid; y_valid follows req of the granted
// producer combinationally and is never conditioned on y_ready.
interface mux4_rr_sched_if #(
    parameter int WIDTH = 8
);
    logic [3:0]       req;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic [3:0]       gnt;
    logic [1:0]       sel;
    logic [WIDTH-1:0] y;
    logic             y_valid;
    logic             y_ready;

    // Scheduler side.
    modport master (
        input  req,
        input  a,
        input  b,
        input  c,
        input  d,
        input  y_ready,
        output gnt,
        output sel,
        output y,
        output y_valid
    );

    // Producer/consumer side.
    modport slave (
        output req,
        output a,
        output b,
        output c,
        output d,
        output y_ready,
        input  gnt,
        input  sel,
        input  y,
        input  y_valid
    );
endinterface

// File: rtl/mux4_rr_sched.sv
// mux4_rr_sched: round-robin scheduler sharing one 4:1 mux between four
// requesters (a, b, c, d) and presenting the selected data on a
// valid/ready output.
//
// Each tenure is capped at MAX_HOLD transferred beats, and every release is
// followed by exactly one idle cycle before the next grant. The round-robin
// pointer is the registered sel: the next search starts at sel+1.
//
// Optional build macro MUX4_RR_SCHED_LOCK_EN adds a 'lock' input; while it is
// high during a grant the MAX_HOLD cap is suspended and only a drop of the
// granted req ends the tenure.
//
// Debug outputs dbg_state (0 = IDLE, 1 = GRANT) and dbg_hold_cnt expose the
// FSM state and beat counter for checkers.
module mux4_rr_sched #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
`ifdef MUX4_RR_SCHED_LOCK_EN
    input  logic                       lock,
`endif
    mux4_rr_sched_if.master            bus,
    output logic                       dbg_state,
    output logic [$clog2(MAX_HOLD):0]  dbg_hold_cnt
);

    localparam int HW = $clog2(MAX_HOLD) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Registered state.
    state_t          state_q;
    state_t          state_d;
    logic [3:0]      gnt_q;
    logic [3:0]      gnt_d;
    logic [1:0]      sel_q;
    logic [1:0]      sel_d;
    logic [HW-1:0]   hold_q;
    logic [HW-1:0]   hold_d;

    // Combinational helpers.
    logic [1:0]      winner;
    logic            winner_found;
    logic [1:0]      cand;
    logic [WIDTH-1:0] mux_data;
    logic            beat_valid;
    logic            xfer;
    logic            at_limit;
    logic            lock_active;

`ifdef MUX4_RR_SCHED_LOCK_EN
    assign lock_active = lock;
`else
    assign lock_active = 1'b0;
`endif

    // Round-robin search: first set req bit in order sel+1, sel+2, sel+3, sel.
    always_comb begin
        winner       = sel_q;
        winner_found = 1'b0;
        cand         = sel_q;
        for (int i = 1; i <= 4; i++) begin
            cand = sel_q + 2'(i);
            if (!winner_found && bus.req[cand]) begin
                winner       = cand;
                winner_found = 1'b1;
            end
        end
    end

    // The shared 4:1 data mux, steered only by the registered select.
    always_comb begin
        mux_data = '0;
        case (sel_q)
            2'd0:    mux_data = bus.a;
            2'd1:    mux_data = bus.b;
            2'd2:    mux_data = bus.c;
            default: mux_data = bus.d;
        endcase
    end

    // Output beat: valid tracks the granted req; data is forced to zero
    // whenever no beat is offered so idle cycles look clean downstream.
    always_comb begin
        beat_valid = 1'b0;
        bus.y      = '0;
        if (state_q == GRANT) begin
            beat_valid = bus.req[sel_q];
            if (beat_valid) begin
                bus.y = mux_data;
            end
        end
        bus.y_valid = beat_valid;
    end

    assign xfer     = beat_valid && bus.y_ready;
    // '>=' rather than '==' so a tenure that ran past the cap under lock
    // releases on the first beat after lock drops.
    assign at_limit = (hold_q >= HW'(MAX_HOLD - 1));

    // Next-state logic: arbitration in IDLE, beat counting and release in GRANT.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (bus.req != 4'b0000) begin
                    state_d = GRANT;
                    sel_d   = winner;
                    gnt_d   = 4'b0001 << winner;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                if (!bus.req[sel_q] || (xfer && at_limit && !lock_active)) begin
                    // sel_q is kept: it is the pointer for the next search.
                    state_d = IDLE;
                    gnt_d   = 4'b0000;
                    hold_d  = '0;
                end else if (xfer && (hold_q != '1)) begin
                    // Saturate so a long locked tenure cannot wrap the counter.
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
                hold_d  = '0;
            end
        endcase
    end

    // State register; reset parks sel at 3 so requester 0 is searched first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'b11;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            hold_q  <= hold_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.sel      = sel_q;
    assign dbg_state    = state_q;
    assign dbg_hold_cnt = hold_q;

    // Structural invariants of the grant register.
    a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(gnt_q));
    a_gnt_matches_state: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == IDLE) == (gnt_q == 4'b0000));
    a_gnt_matches_sel: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == GRANT) |-> (gnt_q == (4'b0001 << sel_q)));

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Testbench for mux4_rr_sched: directed scenarios followed by randomized
// traffic, checked against a queue-based reference model of the scheduler.
module tb_mux4_rr_sched;

    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 4;
    localparam int HW       = $clog2(MAX_HOLD) + 1;
    localparam int HMAX     = (1 << HW) - 1;
`ifdef MUX4_RR_SCHED_LOCK_EN
    localparam bit LOCK_BUILD = 1'b1;
`else
    localparam bit LOCK_BUILD = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]       gnt;
        logic [1:0]       sel;
        logic             valid;
        logic [WIDTH-1:0] y;
        logic             state;
        logic [HW-1:0]    hold;
    } ctl_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mux4_rr_sched_if #(.WIDTH(WIDTH)) bus ();
    logic          dbg_state;
    logic [HW-1:0] dbg_hold_cnt;
    logic          lock_drv;

    mux4_rr_sched #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef MUX4_RR_SCHED_LOCK_EN
        .lock         (lock_drv),
`endif
        .bus          (bus),
        .dbg_state    (dbg_state),
        .dbg_hold_cnt (dbg_hold_cnt)
    );

    // ---------------- scoreboard state ----------------
    logic [WIDTH+1:0] exp_q[$];   // expected beats {sel, data}
    ctl_t             ctl_q[$];   // expected per-cycle control view
    int total = 0;
    int bad   = 0;
    int beats_expected = 0;

    // Reference model: who owns the mux, the last winner, beats so far.
    int   owner;
    int   ptr;
    int   beats;
    logic rst_active;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Drive one cycle of inputs, record what the model says the DUT must show
    // this cycle, advance the model across the coming edge, then wait it out.
    task automatic apply(input logic [3:0] r, input logic rdy,
                         input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db,
                         input logic [WIDTH-1:0] dc, input logic [WIDTH-1:0] dd);
        logic [WIDTH-1:0] data [4];
        ctl_t e;
        logic xfer;
        bus.req     = r;
        bus.y_ready = rdy;
        bus.a = da; bus.b = db; bus.c = dc; bus.d = dd;
        data[0] = da; data[1] = db; data[2] = dc; data[3] = dd;
        xfer = 1'b0;
        if (rst_active || owner < 0) begin
            e.gnt = 4'b0000; e.sel = 2'(ptr); e.valid = 1'b0;
            e.y = '0; e.state = 1'b0; e.hold = '0;
        end else begin
            e.gnt   = 4'(1 << owner);
            e.sel   = 2'(owner);
            e.valid = r[owner];
            e.y     = e.valid ? data[owner] : '0;
            e.state = 1'b1;
            e.hold  = HW'((beats > HMAX) ? HMAX : beats);
            xfer    = e.valid && rdy;
        end
        ctl_q.push_back(e);
        if (xfer) begin
            exp_q.push_back({e.sel, e.y});
            beats_expected++;
        end
        if (!rst_active) begin
            if (owner < 0) begin
                if (r != 4'b0000) begin
                    for (int k = 1; k <= 4; k++)
                        if (owner < 0 && r[(ptr + k) % 4]) owner = (ptr + k) % 4;
                    ptr   = owner;
                    beats = 0;
                end
            end else begin
                if (xfer) beats++;
                if (!r[owner] || (xfer && beats >= MAX_HOLD && !(LOCK_BUILD && lock_drv))) begin
                    owner = -1;
                    beats = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        owner = -1;
        ptr   = 3;
        beats = 0;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        ctl_t e;
        logic [WIDTH+1:0] eb;
        if (ctl_q.size() > 0) begin
            e = ctl_q.pop_front();
            check("gnt",      32'(bus.gnt),      32'(e.gnt));
            check("sel",      32'(bus.sel),      32'(e.sel));
            check("y_valid",  32'(bus.y_valid),  32'(e.valid));
            check("y",        32'(bus.y),        32'(e.y));
            check("state",    32'(dbg_state),    32'(e.state));
            check("hold_cnt", 32'(dbg_hold_cnt), 32'(e.hold));
        end
        if (bus.y_valid === 1'b1 && bus.y_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL beat: got unexpected beat %0h expected none at %0t",
                         {bus.sel, bus.y}, $time);
            end else begin
                eb = exp_q.pop_front();
                check("beat", 32'({bus.sel, bus.y}), 32'(eb));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] r;
        rst_n = 1'b0;
        rst_active = 1'b1;
        lock_drv = 1'b0;
        bus.req = '0; bus.y_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.c = '0; bus.d = '0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset held with every requester asking.
        repeat (3) apply(4'b1111, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44);
        rst_n = 1'b1;
        rst_active = 1'b0;
        repeat (2) apply(4'b1111, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44);
        repeat (2) apply(4'b0000, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);

        // Single requester: capped tenures separated by one bubble.
        repeat (12) apply(4'b0001, 1'b1, 8'hA5, 8'h00, 8'h00, 8'h00);
        repeat (2) apply(4'b0000, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);

        // Full contention.
        repeat (26) apply(4'b1111, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44);
        repeat (2) apply(4'b0000, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);

        // Backpressure on b, then release of the stall.
        repeat (10) apply(4'b0010, 1'b0, 8'h00, 8'h5A, 8'h00, 8'h00);
        repeat (7) apply(4'b0010, 1'b1, 8'h00, 8'h5A, 8'h00, 8'h00);
        repeat (2) apply(4'b0000, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);

        // Early drop on a while c also waits.
        repeat (3) apply(4'b0101, 1'b1, 8'hC1, 8'h00, 8'hC3, 8'h00);
        repeat (4) apply(4'b0100, 1'b1, 8'hC1, 8'h00, 8'hC3, 8'h00);
        repeat (2) apply(4'b0000, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);

        // Asynchronous reset pulse in the middle of a grant on c.
        repeat (2) apply(4'b0100, 1'b0, 8'h00, 8'h00, 8'h77, 8'h00);
        check("pre_rst_gnt", 32'(bus.gnt), 32'(4'b0100));
        #1 rst_n = 1'b0;
        #1;
        check("rst_gnt",     32'(bus.gnt),     32'(4'b0000));
        check("rst_y_valid", 32'(bus.y_valid), 32'(1'b0));
        check("rst_y",       32'(bus.y),       32'(0));
        check("rst_sel",     32'(bus.sel),     32'(2'b11));
        #1 rst_n = 1'b1;
        model_reset();
        repeat (3) apply(4'b1111, 1'b1, 8'h11, 8'h22, 8'h33, 8'h44);

        // Randomized traffic with sticky requests and random backpressure.
        r = 4'b0000;
        for (int n = 0; n < 600; n++) begin
            for (int k = 0; k < 4; k++)
                if ($urandom_range(0, 9) < 2) r[k] = ~r[k];
            lock_drv = ($urandom_range(0, 3) == 0);
            apply(r, ($urandom_range(0, 3) != 0),
                  WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom));
        end
        lock_drv = 1'b0;
        repeat (3) apply(4'b0000, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);

        @(negedge clk);
        #1;
        check("beats_left", 32'(exp_q.size()), 32'(0));
        check("ctl_left",   32'(ctl_q.size()), 32'(0));
        if (beats_expected == 0) begin
            total++;
            bad++;
            $display("FAIL beats_seen: got 0 beats expected some");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux4_rr_sched.md
Name: mux4_rr_sched

Overview:
Round-robin scheduler that shares one 4:1 multiplexer between four requesters (a, b, c, d).
- Arbitrates the req lines and drives the mux sel.
- Presents the selected data on a valid/ready output port.
- Bounds each tenure to MAX_HOLD beats so no requester starves the others.
- Sits between the four producer blocks and a single downstream consumer.

Parameters:
WIDTH, 8, data width of each input and of dout
MAX_HOLD, 4, max beats transferred per grant before forced release; legal range 1..16

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset, asynchronous assert, active-low
req  input  4  request bits; bit0=a, bit1=b, bit2=c, bit3=d
a  input  WIDTH  data from requester 0
b  input  WIDTH  data from requester 1
c  input  WIDTH  data from requester 2
d  input  WIDTH  data from requester 3
gnt  output  4  one-hot grant, registered; 0000 when idle
sel  output  2  mux select, registered; index of current or last grant
y  output  WIDTH  muxed data; 0 when y_valid=0
y_valid  output  1  beat valid
y_ready  input  1  downstream accepts beat

Behaviour:
- Clocking and reset (already decided): one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: state=IDLE, gnt=0000, sel=2'b11 (so requester 0 has first priority), hold_cnt=0, y_valid=0, y=0.
- Reset assertion clears all of these immediately, without waiting for a clock edge.

State IDLE:
- gnt=0000, y_valid=0, y=0.
- If req!=0 at a rising edge, pick the first set bit in search order sel+1, sel+2, sel+3, sel (mod 4).
- At that edge: sel<=winner, gnt<=onehot(winner), hold_cnt<=0, state<=GRANT.
- Arbitration latency is one cycle from req high to gnt.

State GRANT:
- y = mux(a,b,c,d by sel), combinational from the registered sel.
- y_valid = req[sel].
- A beat transfers at a rising edge where y_valid && y_ready.
- On a transfer, hold_cnt increments.

Release from GRANT, evaluated at the edge:
- Condition: (transfer && hold_cnt==MAX_HOLD-1) || !req[sel].
- On release: gnt<=0000, hold_cnt<=0, state<=IDLE; sel keeps the granted index as the round-robin pointer.
- There is always exactly one idle bubble cycle between grants, even when the same single requester re-requests.

Boundary conditions:
- y_ready=0: grant held indefinitely, hold_cnt frozen, y stable as long as the source holds its data.
- A requester dropping req mid-tenure releases at the next edge, with no transfer counted that cycle.
- req changes on non-granted bits never affect the current tenure.
- Simultaneous requests are resolved only by the round-robin order; no fixed priority except immediately after reset.
- MAX_HOLD=1: every grant carries exactly one beat.
- hold_cnt is $clog2(MAX_HOLD)+1 bits wide; it never wraps because release occurs at MAX_HOLD-1.
- gnt is always one-hot or zero; sel is always 0..3.

Optional Feature:
MUX4_RR_SCHED_LOCK_EN
- Defined:
  - Adds input port lock (1 bit).
  - While lock=1 in GRANT, the MAX_HOLD limit is ignored; the tenure ends only when req[sel] drops.
  - lock is sampled only in GRANT; in IDLE it is ignored.
- Undefined:
  - No lock port.
  - The MAX_HOLD limit always applies.

Test Plan:
1. Reset: hold rst_n=0 with req=1111 for 3 cycles -> gnt=0000, sel=11, y_valid=0, y=00 throughout; first grant after rst_n=1 is gnt=0001.
2. Single requester: req=0001, a=8'hA5, y_ready=1 -> one edge later gnt=0001, sel=00, y=A5, y_valid=1 for 4 cycles, then 1 cycle gnt=0000, then regranted.
3. Full contention: req=1111, y_ready=1, a..d=11,22,33,44 -> y sequence 11×4, bubble, 22×4, bubble, 33×4, bubble, 44×4, bubble, 11×4.
4. Backpressure: req=0010, b=8'h5A, y_ready=0 for 10 cycles -> gnt=0010 held, y=5A, hold_cnt=0 throughout; then y_ready=1 -> exactly 4 beats before release.
5. Early drop: req=0101, grant on a; deassert req[0] after 2 beats -> release at the next edge, bubble, gnt=0100 on c.
6. Async reset mid-grant: during GRANT on c, pulse rst_n low between clock edges -> gnt, y_valid and y go to 0 immediately; sel=11 before the next edge.
